// File: rtl/uart_fifo_core.sv
// UART core: free-running baud tick, 16x-oversampling RX, TX, and one RX and one TX FIFO.
// Define UART_PARITY_EN to add an even-parity bit to both directions.
module uart_fifo_core #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR     = 163,
    parameter int unsigned DVSR_BIT = 8,
    parameter int unsigned FIFO_W   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rx,
    input  logic            i_rd_uart,
    input  logic            i_wr_uart,
    input  logic [DBIT-1:0] i_w_data,
    output logic [DBIT-1:0] o_r_data,
    output logic            o_rx_empty,
    output logic            o_tx_full,
    output logic            o_rx_overrun,
    output logic            o_frame_err,
    output logic            o_parity_err,
    output logic            o_tx
);
    localparam int unsigned Depth    = 2 ** FIFO_W;
    localparam logic [5:0]  StopLast = 6'(SB_TICK - 1);
    localparam logic [3:0]  DataLast = 4'(DBIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    logic                rx_meta_q, rx_sync_q;
    logic [DVSR_BIT-1:0] baud_q;
    logic                tick;

    state_e              rx_st_q, rx_st_d, tx_st_q, tx_st_d;
    logic [5:0]          rx_s_q, rx_s_d, tx_s_q, tx_s_d;
    logic [3:0]          rx_n_q, rx_n_d, tx_n_q, tx_n_d;
    logic [DBIT-1:0]     rx_b_q, rx_b_d, tx_b_q, tx_b_d;
    logic                rx_done_q, rx_done_d, frame_set, frame_q, overrun_q;
    logic                tx_q, tx_d, tx_pop;

    logic [DBIT-1:0]     rx_mem_q [Depth];
    logic [DBIT-1:0]     tx_mem_q [Depth];
    logic [FIFO_W-1:0]   rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic                rx_full_q, rx_empty_q, tx_full_q, tx_empty_q;
    logic                rx_do_wr, rx_do_rd, tx_do_wr, tx_do_rd;

    assign tick = (baud_q == DVSR_BIT'(DVSR - 1));

`ifdef UART_PARITY_EN
    logic tx_par_q, tx_par_d, parity_set, parity_q;
    assign o_parity_err = parity_q;
`else
    assign o_parity_err = 1'b0;
`endif

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_s_d    = rx_s_q;
        rx_n_d    = rx_n_q;
        rx_b_d    = rx_b_q;
        rx_done_d = 1'b0;
        frame_set = 1'b0;
`ifdef UART_PARITY_EN
        parity_set = 1'b0;
`endif
        unique case (rx_st_q)
            StIdle: if (!rx_sync_q) begin
                rx_st_d = StStart;
                rx_s_d  = '0;
            end
            // Mid-start re-check rejects glitches shorter than half a bit.
            StStart: if (tick) begin
                if (rx_s_q == 6'd7) begin
                    rx_s_d  = '0;
                    rx_n_d  = '0;
                    rx_st_d = rx_sync_q ? StIdle : StData;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            StData: if (tick) begin
                if (rx_s_q == 6'd15) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == DataLast) begin
`ifdef UART_PARITY_EN
                        rx_st_d = StParity;
`else
                        rx_st_d = StStop;
`endif
                    end else rx_n_d = rx_n_q + 4'd1;
                end else rx_s_d = rx_s_q + 6'd1;
            end
`ifdef UART_PARITY_EN
            StParity: if (tick) begin
                if (rx_s_q == 6'd15) begin
                    rx_s_d     = '0;
                    parity_set = (rx_sync_q != ^rx_b_q);
                    rx_st_d    = StStop;
                end else rx_s_d = rx_s_q + 6'd1;
            end
`endif
            StStop: if (tick) begin
                if (rx_s_q == StopLast) begin
                    rx_st_d   = StIdle;
                    rx_done_d = 1'b1;
                    frame_set = !rx_sync_q;
                end else rx_s_d = rx_s_q + 6'd1;
            end
            default: rx_st_d = StIdle;
        endcase
    end

    always_comb begin
        tx_st_d = tx_st_q;
        tx_s_d  = tx_s_q;
        tx_n_d  = tx_n_q;
        tx_b_d  = tx_b_q;
        tx_d    = 1'b1;
        tx_pop  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d = tx_par_q;
`endif
        unique case (tx_st_q)
            StIdle: if (!tx_empty_q) begin
                tx_pop  = 1'b1;
                tx_b_d  = tx_mem_q[tx_rp_q];
                tx_s_d  = '0;
                tx_n_d  = '0;
                tx_st_d = StStart;
`ifdef UART_PARITY_EN
                tx_par_d = ^tx_mem_q[tx_rp_q];
`endif
            end
            StStart: begin
                tx_d = 1'b0;
                if (tick) begin
                    if (tx_s_q == 6'd15) begin
                        tx_s_d  = '0;
                        tx_st_d = StData;
                    end else tx_s_d = tx_s_q + 6'd1;
                end
            end
            StData: begin
                tx_d = tx_b_q[0];
                if (tick) begin
                    if (tx_s_q == 6'd15) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == DataLast) begin
`ifdef UART_PARITY_EN
                            tx_st_d = StParity;
`else
                            tx_st_d = StStop;
`endif
                        end else tx_n_d = tx_n_q + 4'd1;
                    end else tx_s_d = tx_s_q + 6'd1;
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                tx_d = tx_par_q;
                if (tick) begin
                    if (tx_s_q == 6'd15) begin
                        tx_s_d  = '0;
                        tx_st_d = StStop;
                    end else tx_s_d = tx_s_q + 6'd1;
                end
            end
`endif
            StStop: if (tick) begin
                if (tx_s_q == StopLast) tx_st_d = StIdle;
                else tx_s_d = tx_s_q + 6'd1;
            end
            default: tx_st_d = StIdle;
        endcase
    end

    // A push into a full FIFO is only accepted alongside a pop.
    assign rx_do_wr = rx_done_q && (!rx_full_q || i_rd_uart);
    assign rx_do_rd = i_rd_uart && !rx_empty_q;
    assign tx_do_wr = i_wr_uart && (!tx_full_q || tx_pop);
    assign tx_do_rd = tx_pop && !tx_empty_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            baud_q    <= '0;
            rx_st_q   <= StIdle;
            rx_s_q    <= '0;
            rx_n_q    <= '0;
            rx_b_q    <= '0;
            rx_done_q <= 1'b0;
            tx_st_q   <= StIdle;
            tx_s_q    <= '0;
            tx_n_q    <= '0;
            tx_b_q    <= '0;
            tx_q      <= 1'b1;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q  <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
            baud_q    <= tick ? '0 : baud_q + DVSR_BIT'(1);
            rx_st_q   <= rx_st_d;
            rx_s_q    <= rx_s_d;
            rx_n_q    <= rx_n_d;
            rx_b_q    <= rx_b_d;
            rx_done_q <= rx_done_d;
            tx_st_q   <= tx_st_d;
            tx_s_q    <= tx_s_d;
            tx_n_q    <= tx_n_d;
            tx_b_q    <= tx_b_d;
            tx_q      <= tx_d;
            overrun_q <= (overrun_q & ~rx_do_rd) | (rx_done_q & ~rx_do_wr);
            frame_q   <= (frame_q & ~rx_do_rd) | frame_set;
`ifdef UART_PARITY_EN
            tx_par_q  <= tx_par_d;
            parity_q  <= (parity_q & ~rx_do_rd) | parity_set;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_mem_q   <= '{default: '0};
            tx_mem_q   <= '{default: '0};
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            tx_full_q  <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            if (rx_do_wr) begin
                rx_mem_q[rx_wp_q] <= rx_b_q;
                rx_wp_q           <= rx_wp_q + FIFO_W'(1);
            end
            if (rx_do_rd) rx_rp_q <= rx_rp_q + FIFO_W'(1);
            if (rx_do_wr && !rx_do_rd) begin
                rx_empty_q <= 1'b0;
                rx_full_q  <= (rx_wp_q + FIFO_W'(1) == rx_rp_q);
            end else if (rx_do_rd && !rx_do_wr) begin
                rx_full_q  <= 1'b0;
                rx_empty_q <= (rx_rp_q + FIFO_W'(1) == rx_wp_q);
            end
            if (tx_do_wr) begin
                tx_mem_q[tx_wp_q] <= i_w_data;
                tx_wp_q           <= tx_wp_q + FIFO_W'(1);
            end
            if (tx_do_rd) tx_rp_q <= tx_rp_q + FIFO_W'(1);
            if (tx_do_wr && !tx_do_rd) begin
                tx_empty_q <= 1'b0;
                tx_full_q  <= (tx_wp_q + FIFO_W'(1) == tx_rp_q);
            end else if (tx_do_rd && !tx_do_wr) begin
                tx_full_q  <= 1'b0;
                tx_empty_q <= (tx_rp_q + FIFO_W'(1) == tx_wp_q);
            end
        end
    end

    assign o_r_data     = rx_empty_q ? '0 : rx_mem_q[rx_rp_q];
    assign o_rx_empty   = rx_empty_q;
    assign o_tx_full    = tx_full_q;
    assign o_rx_overrun = overrun_q;
    assign o_frame_err  = frame_q;
    assign o_tx         = tx_q;
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: loopback and bench-driven frames checked against queues.
module tb_uart_fifo_core;
    localparam int unsigned Dvsr = 4;
    localparam int          Bit  = 16 * Dvsr;

    typedef struct packed {
        logic [7:0] data;
        logic       ovr;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, rx_drv, loop_en, rd, wr;
    logic [7:0] wdata, rdata;
    logic       rx_empty, tx_full, ovr, ferr, perr, tx_line, rx_line;
    logic       pop_en, tx_mon_en;

    exp_t       exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;

    assign rx_line = loop_en ? tx_line : rx_drv;

    uart_fifo_core #(
        .DBIT(8), .SB_TICK(16), .DVSR(Dvsr), .DVSR_BIT(3), .FIFO_W(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx_line),
        .i_rd_uart   (rd),
        .i_wr_uart   (wr),
        .i_w_data    (wdata),
        .o_r_data    (rdata),
        .o_rx_empty  (rx_empty),
        .o_tx_full   (tx_full),
        .o_rx_overrun(ovr),
        .o_frame_err (ferr),
        .o_parity_err(perr),
        .o_tx        (tx_line)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, wanted nothing", name, act);
    endfunction

    // RX scoreboard: pop whenever a word is presented and compare against the oldest expectation.
    initial begin
        exp_t e;
        rd = 1'b0;
        forever begin
            @(negedge clk);
            rd = 1'b0;
            if (pop_en && !rst && !rx_empty) begin
                if (exp_q.size() == 0) fail_now("rx_unexpected_word", 32'(rdata));
                else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rdata), 32'(e.data));
                    check("rx_overrun", 32'(ovr), 32'(e.ovr));
                    check("rx_frame_err", 32'(ferr), 32'(e.ferr));
                    check("rx_parity_err", 32'(perr), 32'(e.perr));
                end
                rd = 1'b1;
            end
        end
    end

    // TX line decoder: samples mid-bit from the observed start edge.
    initial begin
        logic [7:0] w;
        forever begin
            @(negedge clk);
            if (tx_mon_en && !tx_line) begin
                repeat (Bit / 2 - 1) @(negedge clk);
                check("tx_start_bit", 32'(tx_line), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Bit) @(negedge clk);
                    w[i] = tx_line;
                end
`ifdef UART_PARITY_EN
                repeat (Bit) @(negedge clk);
                check("tx_parity_bit", 32'(tx_line), 32'(^w));
`endif
                repeat (Bit) @(negedge clk);
                check("tx_stop_bit", 32'(tx_line), 32'd1);
                if (tx_exp_q.size() == 0) fail_now("tx_unexpected_frame", 32'(w));
                else check("tx_word", 32'(w), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] d);
        exp_t e;
        int n = 0;
        while (tx_full && n < 5000) begin
            @(negedge clk);
            n++;
        end
        wr = 1'b1;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
        tx_exp_q.push_back(d);
        if (loop_en) begin
            e = '{data: d, ovr: 1'b0, ferr: 1'b0, perr: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_stop, input logic bad_par);
        exp_t e;
        e = '{data: d, ovr: 1'b0, ferr: bad_stop, perr: bad_par};
        if (!pop_en && exp_q.size() >= 4) begin
            // Dropped frame: the sticky overrun shows up when the oldest word is popped.
            e = exp_q.pop_front();
            e.ovr = 1'b1;
            exp_q.push_front(e);
        end else exp_q.push_back(e);
        rx_drv = 1'b0;
        repeat (Bit) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (Bit) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = (^d) ^ bad_par;
        repeat (Bit) @(negedge clk);
`endif
        if (bad_stop) begin
            rx_drv = 1'b0;
            repeat (40) @(negedge clk);
            rx_drv = 1'b1;
            repeat (Bit - 40) @(negedge clk);
        end else begin
            rx_drv = 1'b1;
            repeat (Bit) @(negedge clk);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_exp_q.size() != 0 || !rx_empty) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 20000), 32'd1);
        repeat (100) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b1; wr = 1'b0; wdata = '0;
        pop_en = 1'b1; tx_mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_line), 32'd1);
        check("reset_rx_empty", 32'(rx_empty), 32'd1);
        check("reset_tx_full", 32'(tx_full), 32'd0);
        check("reset_r_data", 32'(rdata), 32'd0);
        check("reset_flags", {29'd0, ovr, ferr, perr}, 32'd0);
        rst = 1'b0;
        tx_mon_en = 1'b1;
        repeat (20) @(negedge clk);

        // Loopback of a single word, with start-edge latency bound.
        push_tx(8'hA5);
        n = 0;
        while (tx_line && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_latency", 32'(n + 1 <= int'(Dvsr) + 3), 32'd1);
        drain("t1");
        check("t1_empty_after_pop", 32'(rx_empty), 32'd1);

        // Five back-to-back pushes fill the TX FIFO; a sixth is ignored.
        for (int i = 1; i <= 5; i++) push_tx(8'(i));
        check("t2_tx_full", 32'(tx_full), 32'd1);
        wr = 1'b1;
        wdata = 8'h06;
        @(negedge clk);
        wr = 1'b0;
        check("t2_full_holds", 32'(tx_full), 32'd1);
        drain("t2");
        check("t2_tx_not_full", 32'(tx_full), 32'd0);

        repeat (4) push_tx(8'($urandom));
        drain("rand_loop");

        // RX overrun with popping held off.
        loop_en = 1'b0;
        pop_en = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i * 17), 1'b0, 1'b0);
        check("t3_rx_not_empty", 32'(rx_empty), 32'd0);
        check("t3_overrun_set", 32'(ovr), 32'd1);
        pop_en = 1'b1;
        drain("t3");
        check("t3_overrun_cleared", 32'(ovr), 32'd0);

        // Short start glitch.
        rx_drv = 1'b0;
        repeat (3 * Dvsr) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_no_push", 32'(rx_empty), 32'd1);
        check("t4_no_flags", {29'd0, ovr, ferr, perr}, 32'd0);

        send_frame(8'h3C, 1'b1, 1'b0);
        drain("t5_frame");
`ifdef UART_PARITY_EN
        send_frame(8'h3C, 1'b0, 1'b1);
        drain("t5_parity");
`endif
        repeat (4) send_frame(8'($urandom), 1'b0, 1'b0);
        drain("rand_rx");

        // Reset in the middle of both a TX and an RX frame.
        tx_mon_en = 1'b0;
        wr = 1'b1;
        wdata = 8'hC3;
        @(negedge clk);
        wr = 1'b0;
        rx_drv = 1'b0;
        repeat (Bit) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_drv = 1'(8'h5A >> i);
            repeat (Bit) @(negedge clk);
        end
        #2 rst = 1'b1;
        rx_drv = 1'b1;
        #1;
        check("t6_tx_idle_now", 32'(tx_line), 32'd1);
        check("t6_rx_empty", 32'(rx_empty), 32'd1);
        check("t6_tx_not_full", 32'(tx_full), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12 * Bit) @(negedge clk);
        check("t6_no_push_after", 32'(rx_empty), 32'd1);
        check("t6_tx_stays_idle", 32'(tx_line), 32'd1);
        tx_mon_en = 1'b1;
        send_frame(8'h96, 1'b0, 1'b0);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Self-contained UART core: programmable baud-tick generator, 16x-oversampling receiver, transmitter, and one RX FIFO plus one TX FIFO of 2^FIFO_W words each. It replaces the ad-hoc tx/rx/baud/interface wiring in the UART top level with a single parametrised block. Host logic, such as the ALU interface, pushes bytes to transmit and pops received bytes through simple FIFO strobes.

Parameters:
DBIT, 8, data bits per frame (5..9).
SB_TICK, 16, oversample ticks in the stop period: 16/24/32 give 1/1.5/2 stop bits.
DVSR, 163, clocks per oversample tick; DVSR = f_clk/(16*baud), must be >= 2.
DVSR_BIT, 8, width of the divisor counter; must satisfy 2^DVSR_BIT > DVSR.
FIFO_W, 2, address bits per FIFO; depth = 2^FIFO_W.

Ports:
i_clk  in  1  system clock; all logic on the rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_rx  in  1  serial input, idle high; asynchronous to i_clk.
i_rd_uart  in  1  pop one word from the RX FIFO.
i_wr_uart  in  1  push i_w_data into the TX FIFO.
i_w_data  in  DBIT  transmit word.
o_r_data  out  DBIT  RX FIFO head word (first-word fall-through).
o_rx_empty  out  1  RX FIFO empty.
o_tx_full  out  1  TX FIFO full.
o_rx_overrun  out  1  sticky flag: a received frame was dropped.
o_frame_err  out  1  sticky flag: stop bit sampled low.
o_parity_err  out  1  sticky flag: parity mismatch (see Optional Feature).
o_tx  out  1  serial output, idle high.

Behaviour:
- Reset, asynchronous on i_rst high:
  - All counters, FIFO pointers and state registers go to 0; both FSMs go to IDLE.
  - o_tx=1, o_rx_empty=1, o_tx_full=0, all three error flags 0.
  - o_r_data=0 (RX storage is cleared or masked while empty).
  - A frame in progress is abandoned. No partial byte is ever pushed after reset.
- i_rx passes through a 2-flop synchroniser; the RX FSM uses only the synchronised value.
- Baud tick generator:
  - Counter counts 0..DVSR-1 and wraps.
  - The tick is high for one clock when count==DVSR-1.
  - The tick runs freely, independent of traffic.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE -> START on a synchronised low; the tick counter clears.
  - START: at the 8th tick (count 7), re-sample. If the line is high, treat it as a glitch and return to IDLE. If low, clear the counter and go to DATA.
  - DATA: sample every 16 ticks, LSB first, shifting in DBIT bits.
  - STOP: wait SB_TICK ticks, then sample. A low sample sets o_frame_err; the word is still delivered.
- RX push (one clock after STOP completes):
  - If the RX FIFO is not full, push the word.
  - If it is full, discard the word and set o_rx_overrun.
- Error flags: o_rx_overrun, o_frame_err and o_parity_err clear together on any accepted i_rd_uart pop.
- TX FSM (IDLE, START, DATA, STOP):
  - In IDLE with the TX FIFO not empty: pop the head word into the shift register in that clock and go to START.
  - START drives 0 for 16 ticks; DATA sends DBIT bits LSB first, 16 ticks each; STOP drives 1 for SB_TICK ticks; then return to IDLE.
  - Back-to-back words are sent with no extra idle period beyond one clock.
- o_tx is a register output (glitch-free).
- FIFO rules (both FIFOs):
  - Circular buffer with a wr_ptr, an rd_ptr and registered full/empty flags.
  - Push when full is ignored; pop when empty is ignored.
  - Simultaneous push and pop when not full and not empty: both occur, and the count is unchanged.
  - When empty: only the push occurs.
  - When full: both occur, and the FIFO stays full.
  - Pointers wrap modulo 2^FIFO_W.
- o_r_data equals the RX head word combinationally; it changes the clock after a pop.
- Latency:
  - i_wr_uart into an idle, empty core: the o_tx start edge appears within DVSR+3 clocks.
  - RX: o_rx_empty falls 2 clocks after the STOP sample tick, plus 2 synchroniser clocks relative to the line.

Optional Feature:
Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA in both FSMs; it lasts 16 ticks.
  - TX sends even parity: the XOR of the data bits.
  - RX samples the parity bit; a mismatch sets o_parity_err, and the word is still pushed.
  - The frame length grows by one bit.
- Undefined:
  - No PARITY state exists.
  - o_parity_err is tied to 0.
  - Frame = start + DBIT + stop.

Test Plan:
1. DVSR=4, loopback o_tx->i_rx; push 0xA5 -> o_tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then high; o_rx_empty falls; o_r_data=0xA5; after pop, o_rx_empty=1.
2. Push 5 words (0x01..0x05) with FIFO_W=2 in consecutive clocks -> o_tx_full rises after the 4th push with the TX FSM held, or the 5th accepted after the first pop; loopback receives exactly the accepted words in order, with none duplicated.
3. Send 5 frames to i_rx without popping, FIFO_W=2 -> the first 4 words are stored, o_rx_overrun=1; one pop returns word 1 and clears o_rx_overrun.
4. Drive i_rx low for 3 ticks and then high -> RX returns to IDLE, no push, no flags.
5. Frame 0x3C with the stop bit forced low -> o_r_data=0x3C, o_frame_err=1; with UART_PARITY_EN and a wrong parity bit -> o_parity_err=1.
6. Assert i_rst mid-TX-DATA and mid-RX-DATA -> o_tx=1 immediately; both FIFOs empty; no word is pushed after release; the next frame is received correctly.
